// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 binary32 divider: radix-2 restoring mantissa division, QBITS_PER_CYCLE bits/cycle.
// Optional macro FP_DIV_POW2_BYPASS_EN skips the iteration when the divisor is a power of two.
module fp_div_seq #(
  parameter int QBITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  localparam int DIV_CYCLES = 27 / QBITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(DIV_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;

  generate
    if (QBITS_PER_CYCLE != 1 && QBITS_PER_CYCLE != 3) begin : g_bad_qbits
      $error("fp_div_seq: QBITS_PER_CYCLE must be 1 or 3");
    end
  endgenerate

  state_t      state_reg;
  logic [31:0] x_reg, y_reg;
  logic [2:0]  mode_reg;
  logic [26:0] q_reg;
  logic [24:0] rem_reg;
  logic [4:0]  cnt_reg;
  logic        in_ready_reg, out_valid_reg, ovrf_reg, udrf_reg;
  logic [31:0] fp_z_reg;

  logic        sign;
  logic [7:0]  ex, ey;
  logic [22:0] fx, fy;
  logic [23:0] mx, my;
  logic        x_nan, x_inf, x_zero, y_nan, y_inf, y_zero;

  assign sign   = x_reg[31] ^ y_reg[31];
  assign ex     = x_reg[30:23];
  assign ey     = y_reg[30:23];
  assign fx     = x_reg[22:0];
  assign fy     = y_reg[22:0];
  assign mx     = {1'b1, fx};
  assign my     = {1'b1, fy};
  assign x_nan  = (ex == 8'hFF) && (fx != 23'd0);
  assign x_inf  = (ex == 8'hFF) && (fx == 23'd0);
  assign x_zero = (ex == 8'h00);
  assign y_nan  = (ey == 8'hFF) && (fy != 23'd0);
  assign y_inf  = (ey == 8'hFF) && (fy == 23'd0);
  assign y_zero = (ey == 8'h00);

  // Quotient-bit chain: UNPACK seeds it with mx and retires the first bits, DIV continues from rem_reg.
  logic [24:0] seed_rem;
  logic [24:0] rem_last;
  logic [QBITS_PER_CYCLE-1:0] stage_bit;
  logic [26:0] q_next;

  assign seed_rem = (state_reg == UNPACK) ? {1'b0, mx} : rem_reg;

  genvar gi;
  generate
    for (gi = 0; gi < QBITS_PER_CYCLE; gi++) begin : g_step
      logic [24:0] rem_in;
      logic [24:0] rem_out;
      logic [25:0] trial;
      if (gi == 0) begin : g_first
        assign rem_in = seed_rem;
      end else begin : g_chain
        assign rem_in = g_step[gi-1].rem_out;
      end
      assign trial   = {1'b0, rem_in} - {2'b00, my};
      assign stage_bit[QBITS_PER_CYCLE-1-gi] = ~trial[25];
      assign rem_out = trial[25] ? (rem_in << 1) : (trial[24:0] << 1);
    end
  endgenerate

  assign rem_last = g_step[QBITS_PER_CYCLE-1].rem_out;
  assign q_next   = {q_reg[26-QBITS_PER_CYCLE:0], stage_bit};

  logic [23:0]       mant;
  logic              g_bit, r_bit, s_bit, inc, carry, ovf, unf;
  logic signed [9:0] e_pre, e_rnd;
  logic [22:0]       frac_rnd;
  logic [31:0]       round_z, inf_z, max_z;

  assign inf_z = {sign, 8'hFF, 23'd0};
  assign max_z = {sign, 8'hFE, 23'h7FFFFF};

  always_comb begin
    if (q_reg[26]) begin
      mant  = q_reg[26:3];
      g_bit = q_reg[2];
      r_bit = q_reg[1];
      s_bit = q_reg[0] | (|rem_reg);
      e_pre = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;
    end else begin
      mant  = q_reg[25:2];
      g_bit = q_reg[1];
      r_bit = q_reg[0];
      s_bit = |rem_reg;
      e_pre = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd126;
    end
    case (mode_reg)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sign & (g_bit | r_bit | s_bit);
      3'b011:  inc = ~sign & (g_bit | r_bit | s_bit);
      3'b100:  inc = g_bit;
      default: inc = g_bit & (r_bit | s_bit | mant[0]);
    endcase
    // An all-ones mantissa wraps the fraction to zero, which is exactly 2^23 with a bumped exponent.
    carry    = inc & (&mant);
    frac_rnd = mant[22:0] + {22'd0, inc};
    e_rnd    = e_pre + $signed({9'd0, carry});
    ovf      = (e_rnd >= 10'sd255);
    unf      = (e_rnd <= 10'sd0);
    round_z  = {sign, e_rnd[7:0], frac_rnd};
    if (ovf) begin
      case (mode_reg)
        3'b001:  round_z = max_z;
        3'b010:  round_z = sign ? inf_z : max_z;
        3'b011:  round_z = sign ? max_z : inf_z;
        default: round_z = inf_z;
      endcase
    end else if (unf) begin
      round_z = {sign, 31'd0};
    end
  end

  logic        special;
  logic [31:0] special_z;

  always_comb begin
    special   = 1'b1;
    special_z = {sign, 31'd0};
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) special_z = 32'h7FC00000;
    else if (x_inf)  special_z = inf_z;
    else if (y_inf)  special_z = {sign, 31'd0};
    else if (y_zero) special_z = inf_z;
    else if (x_zero) special_z = {sign, 31'd0};
    else             special   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      fp_z_reg      <= 32'd0;
      ovrf_reg      <= 1'b0;
      udrf_reg      <= 1'b0;
      x_reg         <= 32'd0;
      y_reg         <= 32'd0;
      mode_reg      <= 3'd0;
      q_reg         <= 27'd0;
      rem_reg       <= 25'd0;
      cnt_reg       <= 5'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg        <= fp_X;
            y_reg        <= fp_Y;
            mode_reg     <= r_mode;
            in_ready_reg <= 1'b0;
            state_reg    <= UNPACK;
          end
        end
        UNPACK: begin
          if (special) begin
            fp_z_reg      <= special_z;
            ovrf_reg      <= 1'b0;
            udrf_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else
`ifdef FP_DIV_POW2_BYPASS_EN
          if (fy == 23'd0) begin
            q_reg     <= {mx, 3'b000};
            rem_reg   <= 25'd0;
            state_reg <= ROUND;
          end else
`endif
          begin
            q_reg     <= q_next;
            rem_reg   <= rem_last;
            cnt_reg   <= CNT_INIT;
            state_reg <= DIV;
          end
        end
        DIV: begin
          q_reg   <= q_next;
          rem_reg <= rem_last;
          if (cnt_reg == 5'd0) state_reg <= ROUND;
          else                 cnt_reg   <= cnt_reg - 5'd1;
        end
        ROUND: begin
          fp_z_reg      <= round_z;
          ovrf_reg      <= ovf;
          udrf_reg      <= unf & ~ovf;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign fp_Z      = fp_z_reg;
  assign ovrf      = ovrf_reg;
  assign udrf      = udrf_reg;

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Iterative single-precision (IEEE-754 binary32) divider, fp_Z = fp_X / fp_Y.
- Companion to the combinational FP multiplier in the ALU; same subnormal-flush policy, rounding-mode encoding and ovrf/udrf flag semantics.
- Radix-2 restoring mantissa division with a valid/ready handshake on both sides, for the ALU's multi-cycle issue port.

Parameters:
- QBITS_PER_CYCLE, 1, quotient bits retired per iteration cycle; legal values 1 or 3, any other value is an elaboration error.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept (high only in IDLE)
- fp_X  in  32  dividend
- fp_Y  in  32  divisor
- r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- fp_Z  out  32  quotient
- ovrf  out  1  overflow flag
- udrf  out  1  underflow flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: in_ready=1 from the first cycle after reset; out_valid=0; fp_Z=0; ovrf=0; udrf=0; FSM=IDLE.
- Reset mid-operation: the operation is aborted, nothing is emitted, and the block returns to IDLE.
- FSM transitions:
  - IDLE -> UNPACK on in_valid&&in_ready (accept edge t). X, Y and r_mode are captured; in_ready drops.
  - UNPACK -> DIV for normal operands.
  - UNPACK -> DONE for special cases, with fp_Z and flags set directly.
  - DIV runs 27/QBITS_PER_CYCLE cycles, then -> ROUND.
  - ROUND -> DONE.
  - DONE holds out_valid and all outputs stable until out_ready. DONE && out_ready -> IDLE; out_valid falls on the next cycle.
- Latency: out_valid rises 27/QBITS_PER_CYCLE + 2 cycles after t (29 at the default). Special cases: 2 cycles.
- Subnormal inputs (exponent 0) are treated as signed zero.
- Sign: s = X[31]^Y[31].
- Special cases, in priority order:
  - Either operand NaN, 0/0, or inf/inf -> 0x7FC00000.
  - X inf -> {s, inf}.
  - Y inf -> {s, zero}.
  - Y zero -> {s, inf}.
  - X zero -> {s, zero}.
  - Special cases never set ovrf or udrf.
- Mantissa arithmetic:
  - mx = {1, X[22:0]}, my = {1, Y[22:0]}.
  - q = floor((mx<<26)/my), 27 bits; rem = final partial remainder.
  - Restoring step per quotient bit: trial = {rem,next bit} - my; the bit is 1 if trial is non-negative.
- Normalisation:
  - q[26]=1: mant=q[26:3], G=q[2], R=q[1], S=q[0]|(rem!=0); e = Ex-Ey+127.
  - q[26]=0: mant=q[25:2], G=q[1], R=q[0], S=(rem!=0); e = Ex-Ey+126.
  - e is computed signed, 10 bits wide.
- Rounding increment:
  - RNE: G&(R|S|mant[0]).
  - RTZ: 0.
  - RDN: s&(G|R|S).
  - RUP: !s&(G|R|S).
  - RMM: G.
  - If the increment carries out (mant reaches 2^24): mant becomes 2^23 and e increments.
- Overflow (e>=255 after rounding): ovrf=1. Result is {s, inf} for RNE and RMM, RUP with s=0, and RDN with s=1. Otherwise the result is {s, 0x7F7FFFFF}.
- Underflow (e<=0 after rounding): udrf=1, result {s, 31'b0} (flush).
- ovrf and udrf are never both 1.
- in_valid is ignored while in_ready=0.

Optional Feature:
- Macro: FP_DIV_POW2_BYPASS_EN.
- Defined: when Y is normal and Y[22:0]==0 (divisor is a power of two), DIV is skipped. UNPACK -> ROUND with mant=mx, G=R=S=0 and e = Ex-Ey+127. Latency 3 cycles; overflow and underflow rules are unchanged.
- Undefined: all normal operands take the full DIV latency.

Test Plan:
- 0x40C00000 / 0x40000000, RNE (6.0/2.0), macro undefined -> fp_Z=0x40400000, ovrf=udrf=0, out_valid exactly 29 cycles after accept; with the macro defined -> same result in 3 cycles.
- 0x3F800000 / 0x40400000 (1/3) -> RNE 0x3EAAAAAB; RTZ 0x3EAAAAAA; RUP 0x3EAAAAAB; flags 0.
- 0x00000000 / 0x80000000 -> 0x7FC00000; 0x3F800000 / 0x80000000 -> 0xFF800000; 0x7F800000 / 0x3F800000 -> 0x7F800000; each with out_valid 2 cycles after accept and no flags.
- 0x7F7FFFFF / 0x3F000000 -> RNE 0x7F800000 with ovrf=1; RTZ 0x7F7FFFFF with ovrf=1.
- 0x00800000 / 0x40000000 (min normal / 2) -> 0x00000000 with udrf=1; 0x80800000 / 0x40000000 -> 0x80000000 with udrf=1.
- Backpressure and reset:
  - out_ready low 5 cycles after out_valid -> fp_Z and flags stable; in_ready=0 and in_valid ignored throughout.
  - rst_n low at cycle 10 of DIV -> next cycle out_valid=0 and in_ready=1; no result is emitted.
